// File: rtl/uart_tx_arbiter_if.sv
// Bundles the producer-side byte handshakes and the UART TX core controls.
// Ports: req_valid/req_data/req_last/req_ready per producer; tx_data/tx_start/tx_done to the UART.
// master: arbiter side. slave: producers plus UART side (testbench).
interface uart_tx_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_last;
    logic [N_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]       tx_data;
    logic                        tx_start;
    logic                        tx_done;

    modport master (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_data, tx_start
    );

    modport slave (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_data, tx_start
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Latency: transfer at T -> tx_start/tx_data at T+1; tx_done at D -> next transfer at D+1 earliest.
// Backpressure: req_ready is one-hot only in ARB (winner) or HOLD (owner); zero while a byte is in flight.
// Ports: clock, reset (sync, active-high), bus (uart_tx_arbiter_if.master), grant_id, busy.
module uart_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    localparam int IDW       = $clog2(N_REQ),
    localparam int BCW       = $clog2(MAX_BURST + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_tx_arbiter_if.master     bus,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    typedef enum logic [1:0] {ARB, SEND, WAIT, HOLD} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [IDW-1:0]        ptr;
    logic [IDW-1:0]        win_id;
    logic [IDW-1:0]        sel_id;
    logic [IDW-1:0]        idx;
    logic                  win_vld;
    logic                  xfer;
    logic                  rel_now;
    logic                  last_q;
    logic [BCW-1:0]        burst_cnt;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [N_REQ-1:0]      ready;

    // Scan from the far end back toward ptr so the requester closest to ptr
    // (in rotating order) is the last one written, i.e. the winner.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % N_REQ);
            if (bus.req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    // A grant is released by end-of-packet or by reaching the burst cap;
    // both at once is still a single release.
    assign rel_now = last_q || (burst_cnt == BCW'(MAX_BURST));

    always_comb begin
        state_nxt = state;
        ready     = '0;
        xfer      = 1'b0;
        sel_id    = grant_id;
        case (state)
            ARB: begin
                sel_id = win_id;
                if (win_vld) begin
                    ready[win_id] = 1'b1;
                    xfer          = 1'b1;
                    state_nxt     = SEND;
                end
            end
            SEND: state_nxt = WAIT;
            WAIT: begin
                if (bus.tx_done) begin
                    state_nxt = rel_now ? ARB : HOLD;
                end
            end
            HOLD: begin
                // Owner keeps the transmitter even while idle; others wait.
                ready[grant_id] = 1'b1;
                if (bus.req_valid[grant_id]) begin
                    xfer      = 1'b1;
                    state_nxt = SEND;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr       <= '0;
            grant_id  <= '0;
            tx_data_q <= '0;
            last_q    <= 1'b0;
            burst_cnt <= '0;
        end else begin
            if (xfer) begin
                tx_data_q <= bus.req_data[sel_id*DATA_WIDTH +: DATA_WIDTH];
                last_q    <= bus.req_last[sel_id];
                grant_id  <= sel_id;
                burst_cnt <= (state == ARB) ? BCW'(1) : burst_cnt + 1'b1;
            end
            if (state == WAIT && bus.tx_done && rel_now) begin
                ptr <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = (state == SEND);
    assign busy          = (state != ARB);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic       clock;
    logic       reset;
    logic [1:0] grant_id;
    logic       busy;
    int         passed;
    int         total;

    uart_tx_arbiter_if #(.N_REQ(4), .DATA_WIDTH(8)) bus ();

    uart_tx_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_done();
        bus.tx_done = 1'b1;
        cyc();
        bus.tx_done = 1'b0;
    endtask

    // From ARB/HOLD with the requester's byte presented: transfer, check
    // SEND and WAIT, then finish the frame. Returns one cycle after tx_done.
    task automatic send_byte(input int id, input logic [7:0] data);
        #1;
        chk("ready_onehot", bus.req_ready, 32'(1 << id));
        cyc();
        chk("send_start", bus.tx_start, 1);
        chk("send_data", bus.tx_data, data);
        chk("send_grant", grant_id, id);
        chk("send_ready0", bus.req_ready, 0);
        cyc();
        chk("wait_start0", bus.tx_start, 0);
        chk("wait_busy", busy, 1);
        pulse_done();
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_done   = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        // Reset state
        chk("rst_start", bus.tx_start, 0);
        chk("rst_data", bus.tx_data, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_ptr", dut.ptr, 0);

        // Single requester 2, one-byte packet
        bus.req_valid       = 4'b0100;
        bus.req_data[23:16] = 8'hA5;
        bus.req_last        = 4'b0100;
        send_byte(2, 8'hA5);
        bus.req_valid = '0;
        chk("single_busy", busy, 0);
        chk("single_ptr", dut.ptr, 3);

        // Round robin from ptr=0: order 0,1,2,3,0
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rr_ptr0", dut.ptr, 0);
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b1111;
        bus.req_data  = 32'h43424140;
        for (int i = 0; i < 5; i++) begin
            send_byte(i % 4, 8'(8'h40 + i % 4));
            chk("rr_arb_idle", busy, 0);
            chk("rr_no_early_start", bus.tx_start, 0);
        end
        chk("rr_ptr_end", dut.ptr, 1);

        // Packet lock: requester 1 sends 10,11,12 while 0 waits
        bus.req_valid = 4'b0011;
        bus.req_last  = 4'b0001;
        bus.req_data  = 32'h0000_1055;
        send_byte(1, 8'h10);
        chk("lock_hold_busy", busy, 1);
        chk("lock_hold_ready", bus.req_ready, 4'b0010);
        bus.req_data[15:8] = 8'h11;
        send_byte(1, 8'h11);
        bus.req_data[15:8] = 8'h12;
        bus.req_last       = 4'b0011;
        send_byte(1, 8'h12);
        chk("lock_release", busy, 0);
        chk("lock_ptr", dut.ptr, 2);
        bus.req_valid = 4'b0001;
        send_byte(0, 8'h55);
        bus.req_valid = '0;

        // Burst cap of 4: requester 3 streams without last, 0 waiting
        bus.req_valid = 4'b1001;
        bus.req_last  = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            bus.req_data[31:24] = 8'(8'h30 + i);
            send_byte(3, 8'(8'h30 + i));
        end
        chk("burst_release", busy, 0);
        chk("burst_ptr", dut.ptr, 0);
        send_byte(0, 8'h55);
        bus.req_data[31:24] = 8'h34;
        send_byte(3, 8'h34);
        chk("burst_resume_hold", busy, 1);
        bus.req_data[31:24] = 8'h35;
        bus.req_last        = 4'b1001;
        send_byte(3, 8'h35);
        chk("burst_done_ptr", dut.ptr, 0);
        bus.req_valid = '0;
        bus.req_last  = '0;

        // Spurious tx_done in ARB, SEND and HOLD; withdrawn valid in HOLD
        pulse_done();
        chk("spur_arb_busy", busy, 0);
        chk("spur_arb_start", bus.tx_start, 0);
        bus.req_valid       = 4'b0100;
        bus.req_data[23:16] = 8'h77;
        #1;
        chk("spur_ready", bus.req_ready, 4'b0100);
        cyc();
        chk("spur_send_start", bus.tx_start, 1);
        bus.tx_done = 1'b1;
        cyc();
        bus.tx_done = 1'b0;
        chk("spur_send_busy", busy, 1);
        chk("spur_send_ready0", bus.req_ready, 0);
        chk("spur_send_start0", bus.tx_start, 0);
        cyc();
        chk("spur_wait_stays", bus.req_ready, 0);
        pulse_done();
        chk("spur_hold_ready", bus.req_ready, 4'b0100);
        bus.req_valid = 4'b0010;
        pulse_done();
        chk("hold_idle_start", bus.tx_start, 0);
        chk("hold_idle_busy", busy, 1);
        chk("hold_idle_ready", bus.req_ready, 4'b0100);
        cyc();
        cyc();
        chk("hold_idle_busy2", busy, 1);
        chk("hold_idle_grant", grant_id, 2);
        bus.req_valid       = 4'b0110;
        bus.req_data[23:16] = 8'h78;
        bus.req_last        = 4'b0100;
        send_byte(2, 8'h78);
        chk("hold_ptr", dut.ptr, 3);
        bus.req_valid = '0;

        // Reset during WAIT
        bus.req_valid      = 4'b0010;
        bus.req_data[15:8] = 8'h99;
        bus.req_last       = 4'b0010;
        #1;
        chk("rw_ready", bus.req_ready, 4'b0010);
        cyc();
        bus.req_valid = '0;
        cyc();
        chk("rw_wait_busy", busy, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rw_start", bus.tx_start, 0);
        chk("rw_busy", busy, 0);
        chk("rw_grant", grant_id, 0);
        chk("rw_ptr", dut.ptr, 0);
        bus.req_valid      = 4'b0010;
        bus.req_data[15:8] = 8'h9A;
        send_byte(1, 8'h9A);
        chk("rw_after_busy", busy, 0);
        chk("rw_after_ptr", dut.ptr, 2);
        bus.req_valid = '0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
